bram_stream_reader: RTL and testbench
=====================================

Name: bram_stream_reader

Overview:
- FIFO built around a simple-dual-port block RAM with a registered, clock-enabled read port.
- A producer writes raw entries (wr_en/wr_data). The block acts as the read end: it manages the read pointer, issues RAM reads and hides the 1-cycle RAM read latency behind a 2-entry skid buffer.
- Output is a valid/ready stream that sustains 1 entry/cycle.
- Used wherever the link/fire datapath buffers flits in BRAM and drains them to a flow-controlled consumer.

Parameters:
- WIDTH, 8: data width in bits.
- ADDRESSWIDTH, 6: RAM address width.
- DEPTH, 34: RAM entries. Need not be a power of 2. Legal range 2 <= DEPTH <= 2**ADDRESSWIDTH.
- LEVELWIDTH, 7: width of the level output. Must hold DEPTH+2.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset_n  in  1  synchronous, active-low reset.
- wr_en  in  WIDTH-independent 1  producer write strobe.
- wr_data  in  WIDTH  write data.
- wr_full  out  1  RAM holds DEPTH entries.
- wr_overflow  out  1  sticky: a write was attempted while wr_full=1.
- rd_valid  out  1  rd_data holds a valid entry.
- rd_ready  in  1  consumer accepts the entry.
- rd_data  out  WIDTH  head entry.
- level  out  LEVELWIDTH  total entries held (RAM + in-flight + skid).

Behaviour:
- Reset (reset_n=0 at posedge) clears:
  - wr_ptr, rd_ptr, ram_cnt, inflight, skid_cnt, RAM output register, skid entries;
  - all outputs: wr_full, wr_overflow, rd_valid, rd_data, level = 0.
- RAM contents are not reset.
- Reset mid-operation discards every held entry, including any in-flight read.
- Write acceptance:
  - wr_acc = wr_en & ~wr_full.
  - On wr_acc: RAM[wr_ptr] <= wr_data; wr_ptr advances.
  - wr_en & wr_full: data dropped, pointers unchanged, wr_overflow <= 1. It stays 1 until reset.
- Pointer wrap: a pointer equal to DEPTH-1 advances to 0. Addresses >= DEPTH are never generated.
- wr_full is registered and equals (ram_cnt == DEPTH).
  - A write in the same cycle as a fetch from a full RAM is still rejected. This is a decided conservative rule.
- pop = rd_valid & rd_ready.
- fetch = (ram_cnt != 0) & ((skid_cnt + inflight - pop) < 2).
  - fetch drives the RAM read clock-enable, with read address rd_ptr.
  - rd_ptr advances; inflight <= fetch.
- ram_cnt next = ram_cnt + wr_acc - fetch. Simultaneous accept and fetch leaves it unchanged.
- Cycle after a fetch: the RAM output register holds the data and is pushed into the skid tail.
- Skid buffer: 2-entry queue. Head drives rd_data; rd_valid = (skid_cnt != 0).
  - pop removes the head.
  - Push and pop in the same cycle keep order.
  - Occupancy never exceeds 2, by the fetch rule.
- rd_data holds its value while rd_valid & ~rd_ready (AXI-style stability). rd_valid never drops without a pop.
- Read-during-write: a write at cycle t is readable by a fetch at t+1 (RAM updated at the t edge).
- Latency: wr_acc at cycle t -> rd_valid at t+3 (fetch t+1, RAM register t+2, skid t+3), when the FIFO was empty.
- Throughput: with rd_ready held at 1 and the RAM non-empty, one pop per cycle continuously.
- level = ram_cnt + inflight + skid_cnt, registered. Maximum DEPTH+2.

Decomposition:
- Shared package: ptr_t (ADDRESSWIDTH bits) and the wrap-increment function. Shared with the writer-side blocks.
- One sub-module, fire_sdp_ram:
  - simple-dual-port RAM, ram_style block;
  - write port: a, din, we;
  - read port: dpra, qdpo_ce, qdpo, with a registered output cleared by reset_n.
- Pointer/count/skid control lives in bram_stream_reader.

Test Plan:
- Reset then idle -> rd_valid=0, level=0, wr_full=0, wr_overflow=0 throughout.
- Single write 0xA5 at cycle 10, rd_ready=1 -> rd_valid=1 with rd_data=0xA5 at cycle 13 for exactly 1 cycle; level 1 during cycles 11-13, 0 at cycle 14.
- rd_ready=0, write 36 entries 0..35 -> wr_full=1 once ram_cnt=34 (after 36 accepted: 2 in skid, 34 in RAM). level=36. 37th write sets wr_overflow=1, data dropped. Then rd_ready=1 -> 0..35 in order, back-to-back, no bubbles.
- Streaming across wrap: 100 writes/cycle with rd_ready=1 -> outputs 0..99 in order, 1/cycle after the 3-cycle fill. rd_ptr passes 33->0 with no skip or duplicate.
- Random rd_ready (50%) with random writes, scoreboarded -> order preserved; rd_data stable while stalled; level always equals the scoreboard depth.
- Assert reset_n=0 for 1 cycle with 5 entries held and a fetch in flight -> next cycle rd_valid=0, level=0, wr_overflow=0. A following write 0x3C appears 3 cycles later.

Source files
------------

// File: rtl/bram_stream_reader_pkg.sv
// rtl/bram_stream_reader_pkg.sv - shared pointer type and wrap-increment helper
package bram_stream_reader_pkg;

  localparam int unsigned PTR_W = 6;

  typedef logic [PTR_W-1:0] ptr_t;

  // Pointers wrap at depth-1 so non-power-of-2 RAMs never see an out-of-range address
  function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/bram_stream_reader_ram.sv
// rtl/bram_stream_reader_ram.sv - simple-dual-port block RAM with registered, clock-enabled read port
module fire_sdp_ram #(
  parameter int          WIDTH        = 8,
  parameter int          ADDRESSWIDTH = 6,
  parameter int unsigned DEPTH        = 34
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [ADDRESSWIDTH-1:0] a,
  input  logic [WIDTH-1:0]        din,
  input  logic                    we,
  input  logic [ADDRESSWIDTH-1:0] dpra,
  input  logic                    qdpo_ce,
  output logic [WIDTH-1:0]        qdpo
);

  (* ram_style = "block" *) logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[a] <= din;
    end
  end

  // Contents are never reset; only the output register is
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      qdpo <= '0;
    end else if (qdpo_ce) begin
      qdpo <= mem_q[dpra];
    end
  end

endmodule

// File: rtl/bram_stream_reader.sv
// rtl/bram_stream_reader.sv - read end of a BRAM FIFO; hides RAM read latency behind a 2-entry skid
module bram_stream_reader
  import bram_stream_reader_pkg::*;
#(
  parameter int          WIDTH        = 8,
  parameter int          ADDRESSWIDTH = PTR_W,
  parameter int unsigned DEPTH        = 34,
  parameter int          LEVELWIDTH   = 7
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      wr_data,
  output logic                  wr_full,
  output logic                  wr_overflow,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [WIDTH-1:0]      rd_data,
  output logic [LEVELWIDTH-1:0] level
);

  logic [ADDRESSWIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LEVELWIDTH-1:0]   ram_cnt_q, ram_cnt_d, level_q;
  logic                    inflight_q, inflight_d;
  logic [1:0]              skid_cnt_q, skid_cnt_d;
  logic [WIDTH-1:0]        skid0_q, skid0_d, skid1_q, skid1_d;
  logic                    wr_full_q, wr_overflow_q, wr_overflow_d;
  logic [WIDTH-1:0]        ram_q;
  logic                    wr_acc, pop, fetch;
  logic [2:0]              pending;

  assign wr_acc = wr_en & ~wr_full_q;
  assign pop    = rd_valid & rd_ready;

  // Skid entries plus the read in flight, after this cycle's pop, must leave room for one more
  assign pending = {1'b0, skid_cnt_q} + {2'b0, inflight_q} - {2'b0, pop};
  assign fetch   = (ram_cnt_q != '0) && (pending < 3'd2);

  assign wr_ptr_d      = wr_acc ? ADDRESSWIDTH'(wrap_inc(32'(wr_ptr_q), DEPTH)) : wr_ptr_q;
  assign rd_ptr_d      = fetch  ? ADDRESSWIDTH'(wrap_inc(32'(rd_ptr_q), DEPTH)) : rd_ptr_q;
  assign ram_cnt_d     = ram_cnt_q + LEVELWIDTH'(wr_acc) - LEVELWIDTH'(fetch);
  assign inflight_d    = fetch;
  assign wr_overflow_d = wr_overflow_q | (wr_en & wr_full_q);

  always_comb begin
    skid0_d    = skid0_q;
    skid1_d    = skid1_q;
    skid_cnt_d = skid_cnt_q;
    case ({inflight_q, pop})
      2'b01: begin
        skid0_d    = skid1_q;
        skid_cnt_d = skid_cnt_q - 2'd1;
      end
      2'b10: begin
        if (skid_cnt_q == 2'd0) skid0_d = ram_q;
        else                    skid1_d = ram_q;
        skid_cnt_d = skid_cnt_q + 2'd1;
      end
      2'b11: begin
        if (skid_cnt_q == 2'd1) begin
          skid0_d = ram_q;
        end else begin
          skid0_d = skid1_q;
          skid1_d = ram_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      ram_cnt_q     <= '0;
      inflight_q    <= 1'b0;
      skid_cnt_q    <= '0;
      skid0_q       <= '0;
      skid1_q       <= '0;
      wr_full_q     <= 1'b0;
      wr_overflow_q <= 1'b0;
      level_q       <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      ram_cnt_q     <= ram_cnt_d;
      inflight_q    <= inflight_d;
      skid_cnt_q    <= skid_cnt_d;
      skid0_q       <= skid0_d;
      skid1_q       <= skid1_d;
      wr_full_q     <= (ram_cnt_d == LEVELWIDTH'(DEPTH));
      wr_overflow_q <= wr_overflow_d;
      level_q       <= ram_cnt_d + LEVELWIDTH'(inflight_d) + LEVELWIDTH'(skid_cnt_d);
    end
  end

  fire_sdp_ram #(
    .WIDTH        (WIDTH),
    .ADDRESSWIDTH (ADDRESSWIDTH),
    .DEPTH        (DEPTH)
  ) u_ram (
    .clk     (clk),
    .reset_n (reset_n),
    .a       (wr_ptr_q),
    .din     (wr_data),
    .we      (wr_acc),
    .dpra    (rd_ptr_q),
    .qdpo_ce (fetch),
    .qdpo    (ram_q)
  );

  assign wr_full     = wr_full_q;
  assign wr_overflow = wr_overflow_q;
  assign rd_valid    = (skid_cnt_q != 2'd0);
  assign rd_data     = skid0_q;
  assign level       = level_q;

endmodule

// File: tb/tb_bram_stream_reader.sv
// tb/tb_bram_stream_reader.sv - self-checking bench for bram_stream_reader
module tb_bram_stream_reader;

  localparam int DEPTH = 34;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       wr_full;
  logic       wr_overflow;
  logic       rd_valid;
  logic       rd_ready;
  logic [7:0] rd_data;
  logic [6:0] level;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] model_q[$];
  logic       stall_prev;
  logic [7:0] stall_data;
  int         first_k, last_k, n_seen;
  logic [7:0] exp_next;
  logic       do_wr, do_rdy;

  always #5 clk = ~clk;

  bram_stream_reader dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .wr_full     (wr_full),
    .wr_overflow (wr_overflow),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .rd_data     (rd_data),
    .level       (level)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n  = 1'b0;
    wr_en    = 1'b0;
    wr_data  = 8'h00;
    rd_ready = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;

    // idle after reset
    for (int k = 0; k < 6; k++) begin
      check("idle_valid", 32'(rd_valid), 32'd0);
      check("idle_level", 32'(level), 32'd0);
      check("idle_full", 32'(wr_full), 32'd0);
      check("idle_ovf", 32'(wr_overflow), 32'd0);
      tick();
    end

    // single write, 3-cycle latency, one-cycle valid
    rd_ready = 1'b1;
    wr_en    = 1'b1;
    wr_data  = 8'hA5;
    tick();
    wr_en = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      check("single_valid", 32'(rd_valid), (k == 3) ? 32'd1 : 32'd0);
      check("single_level", 32'(level), (k <= 3) ? 32'd1 : 32'd0);
      if (k == 3) check("single_data", 32'(rd_data), 32'hA5);
      tick();
    end

    // fill to full with consumer stalled
    rd_ready = 1'b0;
    for (int i = 0; i < 36; i++) begin
      if (i == 35) check("fill_not_full_early", 32'(wr_full), 32'd0);
      wr_en   = 1'b1;
      wr_data = 8'(i);
      tick();
    end
    wr_en = 1'b0;
    check("fill_level", 32'(level), 32'd36);
    check("fill_full", 32'(wr_full), 32'd1);
    check("fill_ovf_clear", 32'(wr_overflow), 32'd0);
    check("fill_head", 32'(rd_data), 32'd0);
    wr_en   = 1'b1;
    wr_data = 8'hEE;
    tick();
    wr_en = 1'b0;
    check("overflow_set", 32'(wr_overflow), 32'd1);
    check("overflow_level", 32'(level), 32'd36);
    check("stall_head_stable", 32'(rd_data), 32'd0);
    rd_ready = 1'b1;
    for (int i = 0; i < 36; i++) begin
      check("drain_valid", 32'(rd_valid), 32'd1);
      check("drain_data", 32'(rd_data), 32'(i));
      tick();
    end
    check("drain_empty_valid", 32'(rd_valid), 32'd0);
    check("drain_empty_level", 32'(level), 32'd0);
    check("drain_not_full", 32'(wr_full), 32'd0);

    // 100 back-to-back writes streaming across the pointer wrap
    first_k  = -1;
    last_k   = -1;
    n_seen   = 0;
    exp_next = 8'd0;
    for (int k = 0; k < 110; k++) begin
      if (rd_valid) begin
        check("stream_data", 32'(rd_data), 32'(exp_next));
        exp_next = exp_next + 8'd1;
        if (first_k < 0) first_k = k;
        last_k = k;
        n_seen++;
      end
      wr_en   = (k < 100);
      wr_data = 8'(k);
      tick();
    end
    wr_en = 1'b0;
    check("stream_count", 32'(n_seen), 32'd100);
    check("stream_first", 32'(first_k), 32'd3);
    check("stream_last", 32'(last_k), 32'd102);
    check("ovf_sticky", 32'(wr_overflow), 32'd1);

    // reset with entries held and a fetch issued in the reset cycle
    rd_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wr_en   = 1'b1;
      wr_data = 8'(10 + i);
      tick();
    end
    wr_en = 1'b0;
    repeat (3) tick();
    check("pre_reset_level", 32'(level), 32'd5);
    rd_ready = 1'b1;
    reset_n  = 1'b0;
    tick();
    reset_n = 1'b1;
    check("rst_valid", 32'(rd_valid), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_ovf", 32'(wr_overflow), 32'd0);
    check("rst_full", 32'(wr_full), 32'd0);
    wr_en   = 1'b1;
    wr_data = 8'h3C;
    tick();
    wr_en = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      check("post_rst_valid", 32'(rd_valid), (k == 3) ? 32'd1 : 32'd0);
      if (k == 3) check("post_rst_data", 32'(rd_data), 32'h3C);
      tick();
    end
    check("post_rst_level", 32'(level), 32'd0);

    // random traffic against a queue model
    model_q.delete();
    stall_prev = 1'b0;
    stall_data = 8'h00;
    for (int c = 0; c < 900; c++) begin
      check("rand_level", 32'(level), 32'(model_q.size()));
      if (model_q.size() < DEPTH) check("rand_not_full", 32'(wr_full), 32'd0);
      if (stall_prev) begin
        check("rand_hold_valid", 32'(rd_valid), 32'd1);
        check("rand_hold_data", 32'(rd_data), 32'(stall_data));
      end
      if (rd_valid) begin
        if (model_q.size() == 0) check("rand_spurious_valid", 32'd1, 32'd0);
        else check("rand_data", 32'(rd_data), 32'(model_q[0]));
      end
      do_wr  = ($urandom_range(0, 99) < 60) && (model_q.size() < DEPTH);
      do_rdy = ($urandom_range(0, 1) == 1);
      wr_en    = do_wr;
      wr_data  = 8'($urandom_range(0, 255));
      rd_ready = do_rdy;
      if (rd_valid && do_rdy && model_q.size() != 0) void'(model_q.pop_front());
      if (do_wr) model_q.push_back(wr_data);
      stall_prev = rd_valid && !do_rdy;
      stall_data = rd_data;
      tick();
    end
    wr_en    = 1'b0;
    rd_ready = 1'b1;
    for (int c = 0; c < 60; c++) begin
      if (rd_valid) begin
        if (model_q.size() == 0) check("drain2_spurious_valid", 32'd1, 32'd0);
        else check("drain2_data", 32'(rd_data), 32'(model_q.pop_front()));
      end
      tick();
    end
    check("drain2_model_empty", 32'(model_q.size()), 32'd0);
    check("drain2_level", 32'(level), 32'd0);
    check("rand_no_ovf", 32'(wr_overflow), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
